// File: rtl/pic8259_pkg.sv
// Shared types and decode constants for the 8259 bus control sequencer.
// Optional feature macro used by the top: PIC8259_PROTOCOL_ERROR_EN.
package pic8259_pkg;

   typedef enum logic [1:0] {
      READY     = 2'd0,
      WAIT_ICW2 = 2'd1,
      WAIT_ICW3 = 2'd2,
      WAIT_ICW4 = 2'd3
   } init_state_t;

   localparam int ICW1_SEL_BIT  = 4;
   localparam int OCW3_SEL_BIT  = 3;
   localparam int ICW1_SNGL_BIT = 1;
   localparam int ICW1_IC4_BIT  = 0;

   typedef struct packed {
      logic ocw3;
      logic ocw2;
      logic ocw1;
      logic icw4;
      logic icw3;
      logic icw2;
      logic icw1;
   } cmd_strobe_t;

endpackage

// File: rtl/pic8259_strobe_sync.sv
// Multi-stage synchroniser for an active-low asynchronous CPU strobe.
// Resets to 1 so an idle (deasserted) strobe is seen during and after reset.
module pic8259_strobe_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset_n,
   input  logic async_in,
   output logic sync_out
);

   logic [SYNC_STAGES-1:0] stages;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) stages <= '1;
      else          stages <= {stages[SYNC_STAGES-2:0], async_in};
   end

   assign sync_out = stages[SYNC_STAGES-1];

endmodule

// File: rtl/bus_control_sequencer_8259.sv
// Clocked 8259 data-bus control: strobe sync, write commit, ICW/OCW decode and init FSM.
// Define PIC8259_PROTOCOL_ERROR_EN to add protocol_error / error_count outputs.
module bus_control_sequencer_8259
   import pic8259_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  chip_select_n,
   input  logic                  read_enable_n,
   input  logic                  write_enable_n,
   input  logic                  address,
   input  logic [DATA_WIDTH-1:0] data_bus_in,
   output logic [DATA_WIDTH-1:0] internal_data_bus,
   output logic                  write_initial_command_word_1,
   output logic                  write_initial_command_word_2,
   output logic                  write_initial_command_word_3,
   output logic                  write_initial_command_word_4,
   output logic                  write_operation_control_word_1,
   output logic                  write_operation_control_word_2,
   output logic                  write_operation_control_word_3,
   output logic                  read,
   output logic                  read_address,
`ifdef PIC8259_PROTOCOL_ERROR_EN
   output logic                  protocol_error,
   output logic [7:0]            error_count,
`endif
   output logic                  init_busy
);

   logic cs_s, rd_s, wr_s;
   logic wr_prev, cs_prev, read_prev;
   logic pending_valid, pending_a0;
   logic [DATA_WIDTH-1:0] pending_data;
   logic capture, wr_rise, commit, abort, drop;
   logic load_cfg;
   init_state_t state_q, state_d;
   logic single_mode, ic4;
   cmd_strobe_t strobe_d, strobe_q;

   pic8259_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
      .clock(clock), .reset_n(reset_n), .async_in(chip_select_n), .sync_out(cs_s));
   pic8259_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
      .clock(clock), .reset_n(reset_n), .async_in(read_enable_n), .sync_out(rd_s));
   pic8259_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
      .clock(clock), .reset_n(reset_n), .async_in(write_enable_n), .sync_out(wr_s));

   assign capture = ~wr_s & ~cs_s;
   assign wr_rise = wr_s & ~wr_prev;
   // Commit only a captured write whose chip select was still active just before WR rose.
   assign commit  = wr_rise & pending_valid & ~cs_prev;
   assign abort   = wr_rise & pending_valid & cs_prev;

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      state_d  = state_q;
      strobe_d = '0;
      load_cfg = 1'b0;
      drop     = 1'b0;
      if (commit) begin
         if (!pending_a0 && pending_data[ICW1_SEL_BIT]) begin
            strobe_d.icw1 = 1'b1;
            load_cfg      = 1'b1;
            state_d       = WAIT_ICW2;
         end else if (pending_a0) begin
            case (state_q)
               READY: strobe_d.ocw1 = 1'b1;
               WAIT_ICW2: begin
                  strobe_d.icw2 = 1'b1;
                  if (!single_mode) state_d = WAIT_ICW3;
                  else if (ic4)     state_d = WAIT_ICW4;
                  else              state_d = READY;
               end
               WAIT_ICW3: begin
                  strobe_d.icw3 = 1'b1;
                  state_d       = ic4 ? WAIT_ICW4 : READY;
               end
               WAIT_ICW4: begin
                  strobe_d.icw4 = 1'b1;
                  state_d       = READY;
               end
            endcase
         end else if (state_q == READY) begin
            if (pending_data[OCW3_SEL_BIT]) strobe_d.ocw3 = 1'b1;
            else                            strobe_d.ocw2 = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q           <= READY;
         strobe_q          <= '0;
         internal_data_bus <= '0;
         single_mode       <= 1'b0;
         ic4               <= 1'b0;
         wr_prev           <= 1'b1;
         cs_prev           <= 1'b1;
         read_prev         <= 1'b0;
         read_address      <= 1'b0;
         pending_valid     <= 1'b0;
      end else begin
         state_q   <= state_d;
         strobe_q  <= strobe_d;
         wr_prev   <= wr_s;
         cs_prev   <= cs_s;
         read_prev <= read;
         if (|strobe_d) internal_data_bus <= pending_data;
         if (load_cfg) begin
            single_mode <= pending_data[ICW1_SNGL_BIT];
            ic4         <= pending_data[ICW1_IC4_BIT];
         end
         if (read && !read_prev) read_address <= address;
         if (capture)      pending_valid <= 1'b1;
         else if (wr_rise) pending_valid <= 1'b0;
      end
   end

   // NOTE: the pending data register is not reset; pending_valid guards every use of it.
   always_ff @(posedge clock) begin
      if (capture) {pending_a0, pending_data} <= {address, data_bus_in};
   end

`ifdef PIC8259_PROTOCOL_ERROR_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         protocol_error <= 1'b0;
         error_count    <= '0;
      end else begin
         protocol_error <= drop | abort;
         if ((drop || abort) && error_count != 8'hFF) error_count <= error_count + 8'd1;
      end
   end
`endif

   // A concurrent write keeps read low: the write wins.
   assign read      = ~rd_s & ~cs_s & wr_s;
   assign init_busy = (state_q != READY);

   assign write_initial_command_word_1   = strobe_q.icw1;
   assign write_initial_command_word_2   = strobe_q.icw2;
   assign write_initial_command_word_3   = strobe_q.icw3;
   assign write_initial_command_word_4   = strobe_q.icw4;
   assign write_operation_control_word_1 = strobe_q.ocw1;
   assign write_operation_control_word_2 = strobe_q.ocw2;
   assign write_operation_control_word_3 = strobe_q.ocw3;

endmodule

// File: doc/bus_control_sequencer_8259.md
Name: bus_control_sequencer_8259

Overview:
Clocked, parametrised successor to the asynchronous 8259 data-bus control.
- Synchronises the CPU strobes into the core clock domain and detects completed write cycles.
- Decodes the command-word type and tracks the ICW1→ICW2→(ICW3)→(ICW4) initialisation sequence with a state machine.
- Emits single-cycle command-word strobes plus a registered internal data bus to the register/priority logic downstream.

Parameters:
- DATA_WIDTH, 8, width of data_bus_in/internal_data_bus. Must be ≥8; decode uses bits [4:0]; upper bits pass through.
- SYNC_STAGES, 2, flip-flop stages on chip_select_n/read_enable_n/write_enable_n. Must be ≥2.

Ports:
- clock  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- chip_select_n  in  1  CPU chip select, async.
- read_enable_n  in  1  CPU read strobe, async.
- write_enable_n  in  1  CPU write strobe, async.
- address  in  1  A0.
- data_bus_in  in  DATA_WIDTH  CPU write data.
- internal_data_bus  out  DATA_WIDTH  registered captured write data.
- write_initial_command_word_1  out  1  one-cycle strobe.
- write_initial_command_word_2  out  1  one-cycle strobe.
- write_initial_command_word_3  out  1  one-cycle strobe.
- write_initial_command_word_4  out  1  one-cycle strobe.
- write_operation_control_word_1  out  1  one-cycle strobe.
- write_operation_control_word_2  out  1  one-cycle strobe.
- write_operation_control_word_3  out  1  one-cycle strobe.
- read  out  1  synchronised level: read cycle active.
- read_address  out  1  A0 captured at read start.
- init_busy  out  1  high whenever state ≠ READY.

Behaviour:
- Reset (async assert, sync release): all strobes 0, read 0, read_address 0, internal_data_bus 0, state READY, single_mode 0, ic4 0, all sync flops 1.
- Sync: the three strobes pass through SYNC_STAGES flops. wr_s, rd_s and cs_s denote the synchronised values.
- Capture: every cycle with wr_s=0 and cs_s=0, latch {address, data_bus_in} into the pending register.
- Commit: a write commits on the cycle wr_s rises 0→1, and only if cs_s was 0 in the preceding cycle. Otherwise the write is aborted silently.
- On commit: internal_data_bus ← pending data, registered, and exactly one strobe pulses for one cycle.
- Latency: the strobe is asserted SYNC_STAGES+1 clocks after the pin-level write_enable_n rise. internal_data_bus is valid in the same cycle as the strobe.
- Minimum strobe low time: SYNC_STAGES+1 clocks. Shorter pulses may be lost; this is not required to work.
- Decode: ICW1 = A0=0 & D4=1. OCW2 = A0=0 & D4=0 & D3=0. OCW3 = A0=0 & D4=0 & D3=1. A0=1 is ICW2/3/4 or OCW1 according to state.
- FSM states: READY, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4.
  - ICW1, any state: pulse ICW1, latch single_mode=D1 and ic4=D0, go to WAIT_ICW2. This restarts the sequence mid-init.
  - WAIT_ICW2, A0=1: pulse ICW2. Next state is WAIT_ICW3 if !single_mode, else WAIT_ICW4 if ic4, else READY.
  - WAIT_ICW3, A0=1: pulse ICW3. Next state is WAIT_ICW4 if ic4, else READY.
  - WAIT_ICW4, A0=1: pulse ICW4, go to READY.
  - READY, A0=1: pulse OCW1. READY, OCW2/OCW3 decode: pulse the matching strobe.
  - Non-READY state with A0=0 & D4=0: write dropped, no strobe, state unchanged.
- Read: read = ~rd_s & ~cs_s & wr_s. A simultaneous write suppresses read (write wins). read_address is captured on the cycle read rises. Read does not affect the FSM.
- Reset mid-operation returns to READY immediately, and any pending write is discarded.

Optional Feature:
- Macro: PIC8259_PROTOCOL_ERROR_EN.
- Defined: adds output protocol_error (1 bit) and output error_count (8 bits).
  - protocol_error pulses for one cycle on each dropped write, and on each aborted write where CS deasserted before WR rose.
  - error_count saturates at 8'hFF and is cleared by reset only.
- Undefined: neither port exists, and drops/aborts are silent.

Decomposition:
- Package pic8259_pkg holds:
  - the FSM state enum: READY=2'd0, WAIT_ICW2=2'd1, WAIT_ICW3=2'd2, WAIT_ICW4=2'd3;
  - bit-index constants ICW1_SEL_BIT=4, OCW3_SEL_BIT=3, ICW1_SNGL_BIT=1, ICW1_IC4_BIT=0.
- One sub-module, pic8259_strobe_sync: a SYNC_STAGES-deep synchroniser with reset value 1, instantiated three times.

Test Plan:
- Full init, cascade + IC4: ICW1=8'h11, then A0=1 writes 8'h20, 8'h04, 8'h01.
  - Expect ICW1, ICW2, ICW3, ICW4 strobes once each, in order, each SYNC_STAGES+1 clocks after its WR rise.
  - Expect init_busy to fall after ICW4 and internal_data_bus to track each byte.
- Single, no IC4: ICW1=8'h12, then A0=1 8'h08.
  - Expect only ICW1 and ICW2; state READY.
  - A following A0=1 8'hFF gives OCW1 with internal_data_bus=8'hFF.
- In READY: A0=0 8'h20 → OCW2 only; A0=0 8'h0B → OCW3 only.
  - During WAIT_ICW2, A0=0 8'h20 → no strobe, and PROTOCOL_ERROR_EN build shows protocol_error=1 for one cycle.
- Mid-sequence ICW1: 8'h11, 8'h20, then ICW1=8'h13.
  - Expect state WAIT_ICW2 and single_mode=1.
  - Next A0=1 gives ICW2, then ICW4, then READY.
- Abort/read: CS rises before WR rises → no strobe, error_count+1.
  - RD and WR low together → read stays 0.
  - RD low with A0=1 → read=1 after SYNC_STAGES clocks and read_address=1.
- Async reset asserted in WAIT_ICW3 with WR held low → all outputs 0, state READY, no strobe on WR release.
